// File: rtl/rtr_flags_lookup_pipe.sv
// Two-stage multi-lookup flag extractor: stage 1 muxes port/message-class
// slices of the shared flag field, stage 2 combines resource classes.
module rtr_flags_lookup_pipe #(
   parameter int num_message_classes  = 2,
   parameter int num_resource_classes = 2,
   parameter int num_ports            = 5,
   parameter int width                = 1,
   parameter int num_lookups          = 2,
   parameter int combine_mode         = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   output logic in_ready,
   input  logic [0:num_lookups*num_message_classes-1] sel_mc,
   input  logic [0:num_lookups*num_ports-1] route_op,
   input  logic [0:num_lookups*num_resource_classes-1] route_orc,
   input  logic [0:num_ports*num_message_classes*num_resource_classes*width-1] flags_op_opc,
   output logic out_valid,
   input  logic out_ready,
   output logic [0:num_lookups*width-1] flags,
   output logic [0:num_lookups-1] out_err,
   output logic err_sticky,
   input  logic err_clear
);

   localparam int NMC = num_message_classes;
   localparam int NRC = num_resource_classes;
   localparam int NP  = num_ports;
   localparam int W   = width;
   localparam int NL  = num_lookups;
   localparam int SW  = NRC * W;

   logic s1_valid_q, s1_valid_d;
   logic [0:NL*SW-1] s1_rc_q, s1_rc_d;
   logic [0:NL*NRC-1] s1_orc_q, s1_orc_d;
   logic [0:NL-1] s1_err_q, s1_err_d;
   logic s2_valid_q, s2_valid_d;
   logic [0:NL*W-1] s2_flags_q, s2_flags_d;
   logic [0:NL-1] s2_err_q, s2_err_d;
   logic err_sticky_q, err_sticky_d;
   logic s1_adv, s2_adv;
   logic [0:SW-1] sel;
   logic [0:W-1] acc;
   logic any_rc, lerr;

   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = s1_adv;

   always_comb begin
      sel        = '0;
      s1_valid_d = s1_valid_q;
      s1_rc_d    = s1_rc_q;
      s1_orc_d   = s1_orc_q;
      s1_err_d   = s1_err_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            for (int i = 0; i < NL; i++) begin
               // AND-OR mux; a bad select is flagged and zeroed later
               sel = '0;
               for (int p = 0; p < NP; p++) begin
                  for (int m = 0; m < NMC; m++) begin
                     if (route_op[i*NP+p] && sel_mc[i*NMC+m]) begin
                        sel = sel | flags_op_opc[(p*NMC+m)*SW +: SW];
                     end
                  end
               end
               s1_rc_d[i*SW +: SW]   = sel;
               s1_orc_d[i*NRC +: NRC] = route_orc[i*NRC +: NRC];
               s1_err_d[i] = !$onehot(sel_mc[i*NMC +: NMC]) ||
                             !$onehot(route_op[i*NP +: NP]);
            end
         end
      end
   end

   always_comb begin
      acc        = '0;
      any_rc     = 1'b0;
      lerr       = 1'b0;
      s2_valid_d = s2_valid_q;
      s2_flags_d = s2_flags_q;
      s2_err_d   = s2_err_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         s2_flags_d = '0;
         s2_err_d   = '0;
         if (s1_valid_q) begin
            for (int i = 0; i < NL; i++) begin
               acc    = (combine_mode != 0) ? {W{1'b1}} : {W{1'b0}};
               any_rc = 1'b0;
               for (int r = 0; r < NRC; r++) begin
                  if (s1_orc_q[i*NRC+r]) begin
                     any_rc = 1'b1;
                     if (combine_mode != 0)
                        acc = acc & s1_rc_q[i*SW+r*W +: W];
                     else
                        acc = acc | s1_rc_q[i*SW+r*W +: W];
                  end
               end
               lerr = s1_err_q[i] | ~any_rc;
               s2_err_d[i] = lerr;
               s2_flags_d[i*W +: W] = lerr ? {W{1'b0}} : acc;
            end
         end
      end
   end

   // a set on consume outranks a same-cycle clear
   always_comb begin
      err_sticky_d = (err_sticky_q & ~err_clear) |
                     (s2_valid_q & out_ready & (|s2_err_q));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_rc_q      <= '0;
         s1_orc_q     <= '0;
         s1_err_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_flags_q   <= '0;
         s2_err_q     <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_rc_q      <= s1_rc_d;
         s1_orc_q     <= s1_orc_d;
         s1_err_q     <= s1_err_d;
         s2_valid_q   <= s2_valid_d;
         s2_flags_q   <= s2_flags_d;
         s2_err_q     <= s2_err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign flags      = s2_flags_q;
   assign out_err    = s2_err_q;
   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_rtr_flags_lookup_pipe.sv
// Bench for rtr_flags_lookup_pipe: OR-mode and AND-mode instances share
// stimulus; a scoreboard queue checks results, order and latency.
module tb_rtr_flags_lookup_pipe;

   typedef struct {
      logic [0:19] fo;
      logic [0:3]  mc;
      logic [0:9]  op;
      logic [0:3]  orc;
      logic [0:1]  ef0;
      logic [0:1]  ef1;
      logic [0:1]  ee;
   } vec_t;

   typedef struct {
      logic [0:1] f0;
      logic [0:1] f1;
      logic [0:1] e;
      int         acc;
      bit         lat;
   } sb_t;

   typedef struct packed {
      logic [0:1] f;
      logic [0:1] e;
   } res_t;

   logic clk = 1'b0;
   logic reset, in_valid, out_ready, err_clear;
   logic [0:3]  sel_mc;
   logic [0:9]  route_op;
   logic [0:3]  route_orc;
   logic [0:19] flags_op_opc;
   logic in_ready0, in_ready1, out_valid0, out_valid1;
   logic [0:1] flags0, flags1, out_err0, out_err1;
   logic err_sticky0, err_sticky1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   sb_t sbq[$];
   vec_t tbl[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rtr_flags_lookup_pipe #(.combine_mode(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .sel_mc(sel_mc), .route_op(route_op), .route_orc(route_orc),
      .flags_op_opc(flags_op_opc), .out_valid(out_valid0),
      .out_ready(out_ready), .flags(flags0), .out_err(out_err0),
      .err_sticky(err_sticky0), .err_clear(err_clear)
   );

   rtr_flags_lookup_pipe #(.combine_mode(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .sel_mc(sel_mc), .route_op(route_op), .route_orc(route_orc),
      .flags_op_opc(flags_op_opc), .out_valid(out_valid1),
      .out_ready(out_ready), .flags(flags1), .out_err(out_err1),
      .err_sticky(err_sticky1), .err_clear(err_clear)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic res_t model(input logic [0:19] fo, input logic [0:3] mc,
                                  input logic [0:9] op, input logic [0:3] orc,
                                  input bit mode);
      res_t r;
      r.f = '0;
      r.e = '0;
      for (int i = 0; i < 2; i++) begin
         int np = 0;
         int nm = 0;
         int p = 0;
         int m = 0;
         bit any = 0;
         logic a = mode;
         for (int k = 0; k < 5; k++) if (op[i*5+k]) begin np++; p = k; end
         for (int k = 0; k < 2; k++) if (mc[i*2+k]) begin nm++; m = k; end
         for (int k = 0; k < 2; k++) begin
            if (orc[i*2+k]) begin
               any = 1;
               if (mode) a = a & fo[(p*2+m)*2+k];
               else      a = a | fo[(p*2+m)*2+k];
            end
         end
         if (np != 1 || nm != 1 || !any) r.e[i] = 1'b1;
         else r.f[i] = a;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      sb_t e;
      if (!reset) begin
         chk("ov_match", 32'(out_valid1), 32'(out_valid0));
         if (out_valid0) begin
            if (out_ready) begin
               chk("sb_nonempty", 32'(sbq.size() != 0), 1);
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  chk("flags_or", 32'(flags0), 32'(e.f0));
                  chk("flags_and", 32'(flags1), 32'(e.f1));
                  chk("err_or", 32'(out_err0), 32'(e.e));
                  chk("err_and", 32'(out_err1), 32'(e.e));
                  if (e.lat) chk("latency", 32'(cyc - e.acc), 2);
               end
            end
         end else begin
            chk("idle_flags", 32'({flags0, flags1, out_err0}), 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [0:19] fo, input logic [0:3] mc,
                       input logic [0:9] op, input logic [0:3] orc,
                       input logic [0:1] ef0, input logic [0:1] ef1,
                       input logic [0:1] ee, input bit lat,
                       output int waited);
      sb_t s;
      int n = 0;
      flags_op_opc = fo;
      sel_mc = mc;
      route_op = op;
      route_orc = orc;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(in_ready0), 1);
      s.f0 = ef0;
      s.f1 = ef1;
      s.e = ee;
      s.acc = cyc;
      s.lat = lat;
      sbq.push_back(s);
      @(posedge clk);
      #1;
      waited = n;
   endtask

   task automatic send_vec(input vec_t v, input bit lat);
      int w;
      send(v.fo, v.mc, v.op, v.orc, v.ef0, v.ef1, v.ee, lat, w);
   endtask

   task automatic send_rand(input bit lat, output int waited);
      logic [0:19] fo;
      logic [0:3] mc, orc;
      logic [0:9] op;
      res_t r0, r1;
      fo = 20'($urandom);
      mc = '0;
      op = '0;
      orc = '0;
      for (int i = 0; i < 2; i++) begin
         mc[i*2 + $urandom_range(0, 1)] = 1'b1;
         op[i*5 + $urandom_range(0, 4)] = 1'b1;
         orc[i*2 +: 2] = 2'($urandom_range(1, 3));
      end
      r0 = model(fo, mc, op, orc, 1'b0);
      r1 = model(fo, mc, op, orc, 1'b1);
      send(fo, mc, op, orc, r0.f, r1.f, r0.e, lat, waited);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int w;
      int stalls;
      logic [0:1] hf, he;

      tbl[0] = '{20'h00040, 4'b1010, 10'b00010_00010, 4'b0110,
                 2'b10, 2'b10, 2'b00};
      tbl[1] = '{20'h83000, 4'b1001, 10'b10000_01000, 4'b1111,
                 2'b11, 2'b01, 2'b00};
      tbl[2] = '{20'h00003, 4'b0110, 10'b00001_01100, 4'b1010,
                 2'b10, 2'b10, 2'b01};
      tbl[3] = '{20'hFFFFF, 4'b1001, 10'b00100_00100, 4'b0100,
                 2'b10, 2'b10, 2'b01};
      tbl[4] = '{20'hFFFFF, 4'b1101, 10'b01000_00100, 4'b1111,
                 2'b01, 2'b01, 2'b10};
      tbl[5] = '{20'h0000C, 4'b1001, 10'b00001_00001, 4'b1101,
                 2'b10, 2'b10, 2'b00};

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      err_clear = 1'b0;
      sel_mc = '0;
      route_op = '0;
      route_orc = '0;
      flags_op_opc = '0;
      tick(2);
      chk("rst_out_valid", 32'(out_valid0), 0);
      chk("rst_flags", 32'(flags0), 0);
      chk("rst_out_err", 32'(out_err0), 0);
      chk("rst_sticky", 32'(err_sticky0), 0);
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      chk("rst_in_ready", 32'(in_ready0), 1);

      for (int i = 0; i < 6; i++) begin
         send_vec(tbl[i], 1'b1);
         in_valid = 1'b0;
         tick(3);
      end
      chk("sticky_set", 32'({err_sticky0, err_sticky1}), 32'b11);

      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      chk("sticky_clear", 32'(err_sticky0), 0);
      send_vec(tbl[3], 1'b1);
      in_valid = 1'b0;
      tick(1);
      chk("sticky_pre", 32'(err_sticky0), 0);
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      chk("sticky_set_wins", 32'(err_sticky0), 1);
      tick(2);

      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         send_rand(1'b1, w);
         stalls += w;
      end
      in_valid = 1'b0;
      chk("stream_stalls", 32'(stalls), 0);
      tick(4);

      out_ready = 1'b0;
      send_vec(tbl[1], 1'b0);
      send_rand(1'b0, w);
      fork
         begin
            send_rand(1'b0, w);
            send_rand(1'b0, w);
            in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready0), 0);
            chk("bp_out_valid", 32'(out_valid0), 1);
            hf = flags0;
            he = out_err0;
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            chk("bp_hold_flags", 32'(flags0), 32'(hf));
            chk("bp_hold_err", 32'(out_err0), 32'(he));
         end
      join
      tick(5);
      chk("bp_drain", 32'(sbq.size()), 0);

      chk("pre_rst_sticky", 32'(err_sticky0), 1);
      send_vec(tbl[1], 1'b1);
      send_vec(tbl[5], 1'b1);
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid0), 0);
      chk("mid_rst_flags", 32'(flags0), 0);
      chk("mid_rst_sticky", 32'(err_sticky0), 0);
      sbq.delete();
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      chk("post_rst_in_ready", 32'(in_ready0), 1);
      send_vec(tbl[0], 1'b1);
      in_valid = 1'b0;
      tick(5);
      chk("final_drain", 32'(sbq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
